// File: rtl/tx_arbiter_seq_recorder_mwmr_pkg.sv
// Shared source encoding and system defaults for the TX arbiter ordering recorder.
package tx_arbiter_seq_recorder_mwmr_pkg;

  typedef enum logic [2:0] {
    SRC_NONE      = 3'd0,
    SRC_A2P_1     = 3'd1,
    SRC_A2P_2     = 3'd2,
    SRC_MASTER    = 3'd3,
    SRC_RX_ROUTER = 3'd4
  } tx_arbiter_sources_t;

  localparam int SEQ_REC_DATA_WIDTH = $bits(tx_arbiter_sources_t);
  localparam int SEQ_REC_FIFO_DEPTH = 16;
  localparam int SEQ_REC_WR_PORTS   = 4;
  localparam int SEQ_REC_RD_PORTS   = 2;

endpackage

// File: rtl/tx_arbiter_seq_recorder_mwmr_mem.sv
// Register-array storage: WR_PORTS indexed write lanes, RD_PORTS show-ahead read lanes.
module tx_arbiter_seq_recorder_mwmr_mem
  import tx_arbiter_seq_recorder_mwmr_pkg::*;
#(
  parameter int DATA_WIDTH = SEQ_REC_DATA_WIDTH,
  parameter int FIFO_DEPTH = SEQ_REC_FIFO_DEPTH,
  parameter int WR_PORTS   = SEQ_REC_WR_PORTS,
  parameter int RD_PORTS   = SEQ_REC_RD_PORTS,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int WCNT_W     = $clog2(WR_PORTS + 1)
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [WCNT_W-1:0]              wr_count,
  input  logic [ADDR_WIDTH-1:0]          wr_ptr,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0]          rd_ptr,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];

  // Lane i lands at wr_ptr+i; the address add wraps naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WR_PORTS; i++) begin
        if (WCNT_W'(i) < wr_count) begin
          mem_r[wr_ptr + ADDR_WIDTH'(i)] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Show-ahead read lanes.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      rd_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_r[rd_ptr + ADDR_WIDTH'(k)];
    end
  end

endmodule

// File: rtl/tx_arbiter_seq_recorder_mwmr.sv
// Multi-write / multi-read ordering FIFO recording TLP source arrival order for the TX arbiter.
module tx_arbiter_seq_recorder_mwmr
  import tx_arbiter_seq_recorder_mwmr_pkg::*;
#(
  parameter int DATA_WIDTH = SEQ_REC_DATA_WIDTH,
  parameter int FIFO_DEPTH = SEQ_REC_FIFO_DEPTH,
  parameter int WR_PORTS   = SEQ_REC_WR_PORTS,
  parameter int RD_PORTS   = SEQ_REC_RD_PORTS,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int WCNT_W     = $clog2(WR_PORTS + 1),
  parameter int RCNT_W     = $clog2(RD_PORTS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           wr_en,
  input  logic [WCNT_W-1:0]              wr_count,
  input  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                           rd_en,
  input  logic [RCNT_W-1:0]              rd_count,
  output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [RD_PORTS-1:0]            rd_valid,
  output logic [ADDR_WIDTH:0]            count,
  output logic [ADDR_WIDTH:0]            available,
  output logic                           empty,
  output logic                           full,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  overflow_r;
  logic                  underflow_r;

  logic [CNT_W-1:0] wr_cnt_s;
  logic [CNT_W-1:0] rd_cnt_s;
  logic [CNT_W-1:0] avail_s;
  logic             wr_req_s;
  logic             rd_req_s;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             mem_we_s;
  logic [CNT_W-1:0] count_next_s;

  // Acceptance uses start-of-cycle state only, so a same-cycle pop never makes room for a push.
  always_comb begin
    wr_cnt_s = CNT_W'(wr_count);
    rd_cnt_s = CNT_W'(rd_count);
    avail_s  = CNT_W'(FIFO_DEPTH) - count_r;
    wr_req_s = wr_en & (wr_count != '0);
    rd_req_s = rd_en & (rd_count != '0);
    wr_acc_s = wr_req_s & (wr_count <= WCNT_W'(WR_PORTS)) & (wr_cnt_s <= avail_s);
    rd_acc_s = rd_req_s & (rd_count <= RCNT_W'(RD_PORTS)) & (rd_cnt_s <= count_r);
    mem_we_s = wr_acc_s & ~flush & ~rst;
    count_next_s = count_r;
    if (wr_acc_s) begin
      count_next_s = count_next_s + wr_cnt_s;
    end else begin
      count_next_s = count_next_s;
    end
    if (rd_acc_s) begin
      count_next_s = count_next_s - rd_cnt_s;
    end else begin
      count_next_s = count_next_s;
    end
  end

  // Pointer, occupancy and sticky error state; rst outranks flush, which keeps the error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_acc_s) wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(wr_count);
      if (rd_acc_s) rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(rd_count);
      count_r <= count_next_s;
      if (wr_req_s && !wr_acc_s) overflow_r  <= 1'b1;
      if (rd_req_s && !rd_acc_s) underflow_r <= 1'b1;
    end
  end

  tx_arbiter_seq_recorder_mwmr_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .WR_PORTS   (WR_PORTS),
    .RD_PORTS   (RD_PORTS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WCNT_W     (WCNT_W)
  ) u_mem (
    .clk      (clk),
    .wr_en    (mem_we_s),
    .wr_count (wr_count),
    .wr_ptr   (wr_ptr_r),
    .wr_data  (wr_data),
    .rd_ptr   (rd_ptr_r),
    .rd_data  (rd_data)
  );

  // Status outputs derive from registered state only.
  always_comb begin
    for (int k = 0; k < RD_PORTS; k++) begin
      rd_valid[k] = (count_r > CNT_W'(k));
    end
    count     = count_r;
    available = avail_s;
    empty     = (count_r == '0);
    full      = (count_r == CNT_W'(FIFO_DEPTH));
    overflow  = overflow_r;
    underflow = underflow_r;
  end

endmodule

// File: tb/tb_tx_arbiter_seq_recorder_mwmr.sv
// Self-checking bench: directed vector table, hand sequences and randomized traffic against a queue model.
module tb_tx_arbiter_seq_recorder_mwmr;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        wr_en;
  logic [2:0]  wr_count;
  logic [11:0] wr_data;
  logic        rd_en;
  logic [1:0]  rd_count;
  logic [5:0]  rd_data;
  logic [1:0]  rd_valid;
  logic [4:0]  count;
  logic [4:0]  available;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  int tests = 0;
  int fails = 0;

  logic [2:0] q[$];
  logic       m_ovf;
  logic       m_udf;

  typedef struct {
    logic        we;
    logic [2:0]  wc;
    logic [11:0] wd;
    logic        re;
    logic [1:0]  rc;
    logic        fl;
    logic        rs;
    int          ecount;
    logic [1:0]  erv;
    logic        eovf;
    logic        eudf;
    int          el0;
    int          el1;
  } vec_t;

  vec_t tbl[14];

  tx_arbiter_seq_recorder_mwmr dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_count  (wr_count),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_count  (rd_count),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .available (available),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a plain queue of entries plus two sticky flags.
  task automatic model_step(input logic we, input logic [2:0] wc, input logic [11:0] wd,
                            input logic re, input logic [1:0] rc, input logic fl, input logic rs);
    int n;
    int space;
    bit w_ok;
    bit r_ok;
    n = q.size();
    space = 16 - n;
    if (rs) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (fl) begin
      q.delete();
    end else begin
      w_ok = we && (wc != 0) && (int'(wc) <= 4) && (int'(wc) <= space);
      r_ok = re && (rc != 0) && (int'(rc) <= 2) && (int'(rc) <= n);
      if (we && wc != 0 && !w_ok) m_ovf = 1'b1;
      if (re && rc != 0 && !r_ok) m_udf = 1'b1;
      if (r_ok) repeat (int'(rc)) void'(q.pop_front());
      if (w_ok) for (int i = 0; i < int'(wc); i++) q.push_back(wd[i*3 +: 3]);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] wc, input logic [11:0] wd,
                       input logic re, input logic [1:0] rc, input logic fl, input logic rs);
    wr_en = we; wr_count = wc; wr_data = wd;
    rd_en = re; rd_count = rc; flush = fl; rst = rs;
    @(posedge clk);
    model_step(we, wc, wd, re, rc, fl, rs);
    #1;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    chk({tag, " count"}, 32'(count), 32'(n));
    chk({tag, " available"}, 32'(available), 32'(16 - n));
    chk({tag, " empty"}, 32'(empty), 32'(n == 0));
    chk({tag, " full"}, 32'(full), 32'(n == 16));
    chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, " underflow"}, 32'(underflow), 32'(m_udf));
    for (int k = 0; k < 2; k++) begin
      chk({tag, " rd_valid"}, 32'(rd_valid[k]), 32'(n > k));
      if (n > k) chk({tag, " rd_data"}, 32'(rd_data[k*3 +: 3]), 32'(q[k]));
    end
  endtask

  initial begin
    m_ovf = 1'b0;
    m_udf = 1'b0;
    //           we    wc    wd       re    rc    fl    rs    cnt rv     ovf   udf   l0  l1
    tbl[0]  = '{1'b0, 3'd0, 12'h000, 1'b0, 2'd0, 1'b0, 1'b1, 0, 2'b00, 1'b0, 1'b0, -1, -1};
    tbl[1]  = '{1'b0, 3'd0, 12'h000, 1'b0, 2'd0, 1'b0, 1'b0, 0, 2'b00, 1'b0, 1'b0, -1, -1};
    tbl[2]  = '{1'b1, 3'd4, 12'h688, 1'b0, 2'd0, 1'b0, 1'b0, 4, 2'b11, 1'b0, 1'b0, 0, 1};
    tbl[3]  = '{1'b1, 3'd2, 12'h02C, 1'b0, 2'd0, 1'b0, 1'b0, 6, 2'b11, 1'b0, 1'b0, 0, 1};
    tbl[4]  = '{1'b0, 3'd0, 12'h000, 1'b1, 2'd2, 1'b0, 1'b0, 4, 2'b11, 1'b0, 1'b0, 2, 3};
    tbl[5]  = '{1'b0, 3'd0, 12'h000, 1'b1, 2'd2, 1'b0, 1'b0, 2, 2'b11, 1'b0, 1'b0, 4, 5};
    tbl[6]  = '{1'b0, 3'd0, 12'h000, 1'b1, 2'd2, 1'b0, 1'b0, 0, 2'b00, 1'b0, 1'b0, -1, -1};
    tbl[7]  = '{1'b0, 3'd0, 12'h000, 1'b1, 2'd1, 1'b0, 1'b0, 0, 2'b00, 1'b0, 1'b1, -1, -1};
    tbl[8]  = '{1'b1, 3'd0, 12'h000, 1'b0, 2'd0, 1'b0, 1'b0, 0, 2'b00, 1'b0, 1'b1, -1, -1};
    tbl[9]  = '{1'b1, 3'd1, 12'h006, 1'b0, 2'd0, 1'b0, 1'b0, 1, 2'b01, 1'b0, 1'b1, 6, -1};
    tbl[10] = '{1'b0, 3'd0, 12'h000, 1'b1, 2'd2, 1'b0, 1'b0, 1, 2'b01, 1'b0, 1'b1, 6, -1};
    tbl[11] = '{1'b1, 3'd1, 12'h007, 1'b1, 2'd1, 1'b0, 1'b0, 1, 2'b01, 1'b0, 1'b1, 7, -1};
    tbl[12] = '{1'b1, 3'd5, 12'hFFF, 1'b0, 2'd0, 1'b0, 1'b0, 1, 2'b01, 1'b1, 1'b1, 7, -1};
    tbl[13] = '{1'b0, 3'd0, 12'h000, 1'b0, 2'd0, 1'b0, 1'b1, 0, 2'b00, 1'b0, 1'b0, -1, -1};

    for (int v = 0; v < 14; v++) begin
      drive(tbl[v].we, tbl[v].wc, tbl[v].wd, tbl[v].re, tbl[v].rc, tbl[v].fl, tbl[v].rs);
      chk($sformatf("vec%0d count", v), 32'(count), 32'(tbl[v].ecount));
      chk($sformatf("vec%0d available", v), 32'(available), 32'(16 - tbl[v].ecount));
      chk($sformatf("vec%0d empty", v), 32'(empty), 32'(tbl[v].ecount == 0));
      chk($sformatf("vec%0d full", v), 32'(full), 32'(tbl[v].ecount == 16));
      chk($sformatf("vec%0d rd_valid", v), 32'(rd_valid), 32'(tbl[v].erv));
      chk($sformatf("vec%0d overflow", v), 32'(overflow), 32'(tbl[v].eovf));
      chk($sformatf("vec%0d underflow", v), 32'(underflow), 32'(tbl[v].eudf));
      if (tbl[v].el0 >= 0) chk($sformatf("vec%0d lane0", v), 32'(rd_data[2:0]), 32'(tbl[v].el0));
      if (tbl[v].el1 >= 0) chk($sformatf("vec%0d lane1", v), 32'(rd_data[5:3]), 32'(tbl[v].el1));
    end

    // Fill to 14, oversize write rejected, then exact fill to 16.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd4, 12'($urandom), 1'b0, 2'd0, 1'b0, 1'b0);
      check_model("fill");
    end
    drive(1'b1, 3'd2, 12'($urandom), 1'b0, 2'd0, 1'b0, 1'b0);
    chk("fill14 count", 32'(count), 32'd14);
    drive(1'b1, 3'd4, 12'($urandom), 1'b0, 2'd0, 1'b0, 1'b0);
    chk("ovf count", 32'(count), 32'd14);
    chk("ovf flag", 32'(overflow), 32'd1);
    drive(1'b1, 3'd2, 12'($urandom), 1'b0, 2'd0, 1'b0, 1'b0);
    chk("full count", 32'(count), 32'd16);
    chk("full flag", 32'(full), 32'd1);
    chk("ovf sticky", 32'(overflow), 32'd1);
    check_model("fill16");

    // Full with simultaneous pop and push: push rejected, pop accepted; flush keeps overflow.
    drive(1'b0, 3'd0, 12'h000, 1'b0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 3'd4, 12'($urandom), 1'b0, 2'd0, 1'b0, 1'b0);
    chk("refill full", 32'(full), 32'd1);
    chk("refill ovf", 32'(overflow), 32'd0);
    drive(1'b1, 3'd2, 12'($urandom), 1'b1, 2'd2, 1'b0, 1'b0);
    chk("rw full count", 32'(count), 32'd14);
    chk("rw full ovf", 32'(overflow), 32'd1);
    check_model("rwfull");
    drive(1'b1, 3'd1, 12'h001, 1'b1, 2'd1, 1'b1, 1'b0);
    chk("flush count", 32'(count), 32'd0);
    chk("flush empty", 32'(empty), 32'd1);
    chk("flush ovf", 32'(overflow), 32'd1);
    drive(1'b0, 3'd0, 12'h000, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("rst ovf", 32'(overflow), 32'd0);

    // Wrap: advance both pointers to 14, then a 4-lane write straddles 15 -> 0.
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 3'd1, 12'($urandom), 1'b0, 2'd0, 1'b0, 1'b0);
      drive(1'b0, 3'd0, 12'h000, 1'b1, 2'd1, 1'b0, 1'b0);
    end
    drive(1'b1, 3'd4, {3'd1, 3'd7, 3'd6, 3'd5}, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("wrap lane0 A", 32'(rd_data[2:0]), 32'd5);
    chk("wrap lane1 B", 32'(rd_data[5:3]), 32'd6);
    drive(1'b0, 3'd0, 12'h000, 1'b1, 2'd2, 1'b0, 1'b0);
    chk("wrap lane0 C", 32'(rd_data[2:0]), 32'd7);
    chk("wrap lane1 D", 32'(rd_data[5:3]), 32'd1);
    drive(1'b0, 3'd0, 12'h000, 1'b1, 2'd2, 1'b0, 1'b0);
    chk("wrap empty", 32'(empty), 32'd1);
    check_model("wrap");

    // Randomized traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), 12'($urandom),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 199) == 0));
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
